dbus_sram_slave: RTL
====================

// Module: dbus_sram_slave
// PURPOSE
//  Responder end of the CPU data bus: accepts dbus_en/we/addr/data from the MM-stage bus master,
//  performs word reads and byte-lane writes on on-chip data RAM after a programmable wait.
//  Drives dbus_stall to freeze the pipeline until the access completes; returns the full aligned word.
//  Load byte/half extraction and sign extension stay on the requester side (it uses word_offset).
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words; power of two; index = dbus_addr[2+:$clog2(DEPTH_WORDS)]
//  WAIT_CYCLES  1     extra cycles spent in BUSY before the access (0..15)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  resetn       in   1   asynchronous, active-low reset
//  dbus_en      in   1   request valid; held stable with we/addr/wdata while dbus_stall=1
//  dbus_we      in   4   byte-lane write enables, already lane-aligned; 4'b0000 = read
//  dbus_addr    in   32  word address; bits [1:0] are 00 by protocol and ignored
//  dbus_wdata   in   32  lane-aligned store data; only lanes with we=1 are used
//  dbus_rdata   out  32  full RAM word, valid in the cycle dbus_stall falls (DONE)
//  dbus_stall   out  1   1 = hold the pipeline; 0 = access finished / bus idle
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE, wait counter=0, dbus_rdata=0, dbus_stall=0 once resetn=0
//    propagates (dbus_en ignored in reset). RAM contents are NOT reset.
//  - FSM: IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: dbus_en=1 -> capture we/addr/wdata, cnt<=WAIT_CYCLES, go BUSY.
//    BUSY: cnt!=0 -> cnt<=cnt-1; cnt==0 -> perform access, go DONE.
//    DONE: one cycle; go IDLE unconditionally (a request present here is taken next cycle in IDLE).
//  - dbus_stall (combinational): (IDLE & dbus_en) | BUSY. DONE drives 0.
//  - Latency: request in cycle t -> DONE at t+2+WAIT_CYCLES; dbus_stall high for 2+WAIT_CYCLES cycles.
//  - Access: for each lane i with we[i]=1, RAM[idx][8i+7:8i] <= wdata[8i+7:8i]; other lanes unchanged.
//    dbus_rdata <= resulting word (post-write value; read returns stored word). Registered, held
//    until the next access completes.
//  - Access uses captured values only; if dbus_en drops during BUSY (protocol violation) the captured
//    transaction still completes, DONE still occurs.
//  - Address bits above the RAM index alias (wrap modulo DEPTH_WORDS); no error signalled.
//  - we=4'b0000 with dbus_en=1 is a read; RAM unchanged.
//  - Back-to-back: DONE->IDLE costs one idle cycle; new request in IDLE follows normal timing.
//  - resetn asserted mid-BUSY: transaction dropped, no RAM write, outputs to reset values.
// STRUCTURE
//  - Shared package dbus_pkg: dbus_state_t enum {IDLE,BUSY,DONE}; WE_READ=4'b0000 and lane-mask
//    constants (BYTE/HALF/WORD, matching the master's encoding); address/data widths via defines.vh.
//  - One sub-module: dbus_ram (DEPTH_WORDS x 32, 4 byte-write enables, synchronous write/read,
//    read-after-write returns new data). FSM, counter, capture regs and dbus_rdata reg stay here.
// TESTING
//  1. Reset: resetn=0 with dbus_en=1 -> dbus_stall=0, dbus_rdata=0; release -> IDLE, no access.
//  2. SW 0x0000_0010 data 0xDEADBEEF we=1111, then read 0x10 (WAIT_CYCLES=1) -> stall 3 cycles each,
//     rdata=0xDEADBEEF in DONE of the read.
//  3. SB lane 2: addr 0x10 we=0100 wdata 0x00AA0000 over 0xDEADBEEF -> read returns 0xDEAABEEF;
//     SH we=0011 wdata 0x00001234 -> 0xDEAA1234.
//  4. Alias: DEPTH_WORDS=1024, write 0x55 to word 0x0000_0004, read 0x0000_1004 -> 0x00000055.
//  5. Timing sweep WAIT_CYCLES=0,3: stall width = 2 and 5 cycles; back-to-back requests get one
//     idle cycle between DONE and next stall; rdata stable between accesses.
//  6. resetn pulsed low during BUSY of SW 0x20=0x11111111 -> read 0x20 after reset returns prior value.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared data-bus definitions: FSM states, bus widths, byte-lane write-enable encodings.
package dbus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LANES  = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } dbus_state_t;

  // Write-enable encodings shared with the bus master (lane-aligned, LSB lane shown).
  localparam logic [LANES-1:0] WE_READ = 4'b0000;
  localparam logic [LANES-1:0] WE_BYTE = 4'b0001;
  localparam logic [LANES-1:0] WE_HALF = 4'b0011;
  localparam logic [LANES-1:0] WE_WORD = 4'b1111;

  // Expand per-lane write enables into a full-width bit mask.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] we);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < LANES; i++) begin
      mask[8*i +: 8] = {8{we[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dbus_ram.sv
// Single-port data RAM: 32-bit words, byte-lane writes, registered write-first read.
module dbus_ram
  import dbus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [LANES-1:0]  we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] mask;

  assign mask = lane_mask(we);

  // Merge enabled lanes into the addressed word; the read port returns the merged word.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[idx] <= (mem[idx] & ~mask) | (wdata & mask);
      rdata    <= (mem[idx] & ~mask) | (wdata & mask);
    end
  end

endmodule

// File: rtl/dbus_sram_slave.sv
// Data-bus responder: captures a request, waits WAIT_CYCLES, performs one RAM access,
// stalls the pipeline until the access completes and returns the resulting word.
module dbus_sram_slave
  import dbus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dbus_en,
  input  logic [LANES-1:0]  dbus_we,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_wdata,
  output logic [DATA_W-1:0] dbus_rdata,
  output logic              dbus_stall
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  dbus_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              access;
  logic              busy_stall;
  logic              rdata_vld_q;

  logic [LANES-1:0]  we_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] ram_rdata;

  // Byte offset and the address bits above the RAM index are intentionally dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dbus_addr[ADDR_W-1:IDX_W+2], dbus_addr[1:0]};

  // FSM state and wait counter; a reset drops any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update, request capture strobe and access strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    access     = 1'b0;
    busy_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dbus_en) begin
          accept     = 1'b1;
          busy_stall = 1'b1;
          cnt_d      = WAIT_INIT;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        busy_stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // While resetn is low the request input must not raise a stall.
  assign dbus_stall = busy_stall & resetn;

  // Capture the request; later changes on the bus do not affect the access in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= dbus_we;
      idx_p0   <= dbus_addr[2 +: IDX_W];
      wdata_p0 <= dbus_wdata;
    end
  end

  // Tracks whether the RAM read register holds a post-reset result; clears rdata in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_vld_q <= 1'b0;
    end else if (access) begin
      rdata_vld_q <= 1'b1;
    end
  end

  dbus_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .en   (access),
    .we   (we_p0),
    .idx  (idx_p0),
    .wdata(wdata_p0),
    .rdata(ram_rdata)
  );

  // The RAM read register only updates on an access, so the returned word is held between accesses.
  assign dbus_rdata = rdata_vld_q ? ram_rdata : '0;

endmodule
